mmio_responder: RTL and testbench



---
 rtl/mmio_pkg.sv | 17 +
 rtl/byte_fifo.sv | 62 ++++++
 rtl/mmio_responder.sv | 148 ++++++++++++++
 tb/tb_mmio_responder.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared constants and state type for the MMIO responder and its FIFOs.
package mmio_pkg;

  localparam logic [2:0] SEL_CHAR   = 3'd0;
  localparam logic [2:0] SEL_STATUS = 3'd1;
  localparam logic [2:0] SEL_FINISH = 3'd4;
  localparam logic [2:0] SEL_CNT_B1 = 3'd5;
  localparam logic [2:0] SEL_CNT_B2 = 3'd6;
  localparam logic [2:0] SEL_CNT_B3 = 3'd7;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/byte_fifo.sv
// Byte-wide synchronous FIFO with head-of-queue output and occupancy count.
// A push while full is accepted only when a pop happens in the same cycle.
module byte_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [7:0]               din_i,
  input  logic                     pop_i,
  output logic [7:0]               dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mmio_responder.sv
// CPU byte-wide MMIO window: TX/RX FIFOs toward the host UART, status, finish handshake.
// Optional feature macro MMIO_CYCLE_CNT_EN adds a 32-bit cycle counter on sel 4-7 reads.
module mmio_responder
  import mmio_pkg::*;
#(
  parameter int unsigned TX_DEPTH = 16,
  parameter int unsigned RX_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rdy,
  input  logic       io_en,
  input  logic [2:0] io_sel,
  input  logic       io_wr,
  input  logic [7:0] io_din,
  output logic [7:0] io_dout,
  output logic       io_full,
  output logic       program_finish,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready
);

  localparam int unsigned TAW = $clog2(TX_DEPTH);
  localparam int unsigned RAW = $clog2(RX_DEPTH);
  localparam logic [TAW:0] IO_FULL_THR = (TAW+1)'(TX_DEPTH - 2);

  logic           req, rd_req, wr_char, wr_fin;
  logic           tx_full, tx_empty, tx_pop, ovf_set;
  logic [TAW:0]   tx_count;
  logic           rx_full, rx_empty, rx_push, rx_pop;
  logic [RAW:0]   rx_count;
  logic [7:0]     rx_head;
  logic [7:0]     io_dout_q, io_dout_d;
  logic           ovf_q, ovf_d;
  state_e         state_q;

  assign req     = rdy & io_en;
  assign rd_req  = req & ~io_wr;
  assign wr_char = req & io_wr & (io_sel == SEL_CHAR);
  assign wr_fin  = req & io_wr & (io_sel == SEL_FINISH);
  assign rx_pop  = rd_req & (io_sel == SEL_CHAR);

  assign tx_valid = ~tx_empty;
  assign tx_pop   = tx_valid & tx_ready;
  assign rx_ready = ~rx_full;
  assign rx_push  = rx_valid & rx_ready;
  assign io_full  = (tx_count >= IO_FULL_THR);
  assign io_dout  = io_dout_q;

  byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (wr_char),
    .din_i   (io_din),
    .pop_i   (tx_pop),
    .dout_o  (tx_data),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .count_o (tx_count)
  );

  byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (rx_push),
    .din_i   (rx_data),
    .pop_i   (rx_pop),
    .dout_o  (rx_head),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .count_o (rx_count)
  );

  // A write into a full TX FIFO is only dropped if the UART is not draining it this cycle.
  assign ovf_set = wr_char & tx_full & ~tx_pop;

  always_comb begin
    ovf_d = ovf_q;
    if (rd_req && (io_sel == SEL_STATUS)) ovf_d = 1'b0;
    if (ovf_set) ovf_d = 1'b1;
  end

`ifdef MMIO_CYCLE_CNT_EN
  logic [31:0] cyc_q, snap_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q  <= '0;
      snap_q <= '0;
    end else begin
      cyc_q <= cyc_q + 32'd1;
      if (rd_req && (io_sel == SEL_FINISH)) snap_q <= cyc_q;
    end
  end
`endif

  always_comb begin
    io_dout_d = io_dout_q;
    if (rd_req) begin
      case (io_sel)
        SEL_CHAR:   io_dout_d = rx_empty ? '0 : rx_head;
        SEL_STATUS: io_dout_d = {5'b0, ovf_q, (rx_count != '0), tx_full};
`ifdef MMIO_CYCLE_CNT_EN
        SEL_FINISH: io_dout_d = cyc_q[7:0];
        SEL_CNT_B1: io_dout_d = snap_q[15:8];
        SEL_CNT_B2: io_dout_d = snap_q[23:16];
        SEL_CNT_B3: io_dout_d = snap_q[31:24];
`endif
        default:    io_dout_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      io_dout_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      io_dout_q <= io_dout_d;
      ovf_q     <= ovf_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= RUN;
      program_finish <= 1'b0;
    end else begin
      program_finish <= 1'b0;
      case (state_q)
        RUN:     if (wr_fin) state_q <= DRAIN;
        DRAIN: begin
          if (tx_empty) begin
            state_q        <= DONE;
            program_finish <= 1'b1;
          end
        end
        DONE:    state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_responder.sv
// Randomized bench for mmio_responder against a queue-based reference model.
module tb_mmio_responder;

  localparam int unsigned TXD = 16;
  localparam int unsigned RXD = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rdy = 1'b1, io_en = 1'b0, io_wr = 1'b0;
  logic [2:0] io_sel = '0;
  logic [7:0] io_din = '0;
  logic [7:0] io_dout;
  logic       io_full, program_finish;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0, rx_ready;

  always #5 clk = ~clk;

  mmio_responder #(.TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rdy            (rdy),
    .io_en          (io_en),
    .io_sel         (io_sel),
    .io_wr          (io_wr),
    .io_din         (io_din),
    .io_dout        (io_dout),
    .io_full        (io_full),
    .program_finish (program_finish),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: byte queues plus a small finish tracker.
  logic [7:0]  txq[$];
  logic [7:0]  rxq[$];
  bit          m_ovf, m_drain, m_pulse;
  logic [7:0]  m_dout;
  logic [31:0] m_cyc, m_snap;

  task automatic model_clear();
    txq.delete(); rxq.delete();
    m_ovf = 0; m_drain = 0; m_pulse = 0;
    m_dout = '0; m_cyc = '0; m_snap = '0;
  endtask

  task automatic check_outputs();
    chk("io_dout", io_dout, m_dout);
    chk("io_full", io_full, (txq.size() >= TXD - 2));
    chk("program_finish", program_finish, m_pulse);
    chk("tx_valid", tx_valid, (txq.size() != 0));
    if (txq.size() != 0) chk("tx_data", tx_data, txq[0]);
    chk("rx_ready", rx_ready, (rxq.size() < RXD));
  endtask

  task automatic step();
    bit req, tx_pop, rx_push, tx_empty_pre, tx_full_pre, new_pulse;
    req          = rdy && io_en;
    tx_empty_pre = (txq.size() == 0);
    tx_full_pre  = (txq.size() == TXD);
    tx_pop       = !tx_empty_pre && tx_ready;
    rx_push      = rx_valid && (rxq.size() < RXD);
    new_pulse    = 0;
    if (m_drain && tx_empty_pre) begin
      m_drain   = 0;
      new_pulse = 1;
    end else if (!m_drain && !m_pulse && req && io_wr && io_sel == 3'd4) begin
      m_drain = 1;
    end
    m_pulse = new_pulse;
    if (tx_pop) void'(txq.pop_front());
    if (req && io_wr && io_sel == 3'd0) begin
      if (txq.size() < TXD) txq.push_back(io_din);
      else m_ovf = 1;
    end
    if (req && !io_wr) begin
      case (io_sel)
        3'd0: m_dout = (rxq.size() != 0) ? rxq.pop_front() : 8'h00;
        3'd1: begin
          m_dout = {5'b0, m_ovf, (rxq.size() != 0), tx_full_pre};
          m_ovf  = 0;
        end
`ifdef MMIO_CYCLE_CNT_EN
        3'd4: begin m_snap = m_cyc; m_dout = m_cyc[7:0]; end
        3'd5: m_dout = m_snap[15:8];
        3'd6: m_dout = m_snap[23:16];
        3'd7: m_dout = m_snap[31:24];
`endif
        default: m_dout = 8'h00;
      endcase
    end
    if (rx_push) rxq.push_back(rx_data);
    m_cyc = m_cyc + 1;
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle_step();
    io_en = 0;
    step();
  endtask

  task automatic bus_wr(input logic [2:0] s, input logic [7:0] d);
    rdy = 1; io_en = 1; io_wr = 1; io_sel = s; io_din = d;
    step();
    io_en = 0;
  endtask

  task automatic bus_rd(input logic [2:0] s);
    rdy = 1; io_en = 1; io_wr = 0; io_sel = s;
    step();
    io_en = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    rdy = 1; io_en = 0; io_wr = 0; io_sel = '0; io_din = '0;
    tx_ready = 0; rx_valid = 0; rx_data = '0;
    model_clear();
    @(posedge clk);
    #2;
    rst_n = 1;
  endtask

  initial begin
    int pulses;
    do_reset();
    chk("rst_io_dout", io_dout, 8'h00);
    chk("rst_io_full", io_full, 1'b0);
    chk("rst_finish", program_finish, 1'b0);
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_rx_ready", rx_ready, 1'b1);

    // Two characters stream out in order.
    tx_ready = 1;
    bus_wr(3'd0, 8'h41);
    chk("t1_first", tx_data, 8'h41);
    bus_wr(3'd0, 8'h42);
    chk("t1_second", tx_data, 8'h42);
    idle_step();
    chk("t1_empty", tx_valid, 1'b0);

    // Back-pressure threshold and overflow flag.
    tx_ready = 0;
    for (int i = 0; i < 13; i++) bus_wr(3'd0, 8'(i + 1));
    chk("t2_full13", io_full, 1'b0);
    bus_wr(3'd0, 8'd14);
    chk("t2_full14", io_full, 1'b1);
    for (int i = 15; i <= 17; i++) bus_wr(3'd0, 8'(i));
    bus_rd(3'd1);
    chk("t2_stat_ovf", io_dout, 8'h05);
    bus_rd(3'd1);
    chk("t2_stat_clr", io_dout, 8'h01);
    tx_ready = 1;
    for (int i = 0; i < 18; i++) idle_step();

    // RX byte delivered once, then empty read returns zero.
    rx_valid = 1; rx_data = 8'h7A;
    idle_step();
    rx_valid = 0;
    bus_rd(3'd0);
    chk("t3_rx", io_dout, 8'h7A);
    bus_rd(3'd0);
    chk("t3_rx_empty", io_dout, 8'h00);

    // Finish while TX holds three bytes.
    tx_ready = 0;
    bus_wr(3'd0, 8'hA1); bus_wr(3'd0, 8'hA2); bus_wr(3'd0, 8'hA3);
    bus_wr(3'd4, 8'h00);
    for (int i = 0; i < 5; i++) idle_step();
    tx_ready = 1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      idle_step();
      if (program_finish) pulses++;
    end
    chk("t4_pulses", pulses, 1);

    // Finish with TX empty: pulse visible after the second edge.
    bus_wr(3'd4, 8'h00);
    chk("t7_no_pulse_yet", program_finish, 1'b0);
    idle_step();
    chk("t7_pulse", program_finish, 1'b1);
    idle_step();

    // Requests ignored while the bus is not owned.
    rx_valid = 1; rx_data = 8'h33;
    idle_step();
    rx_valid = 0;
    rdy = 0; io_en = 1; io_wr = 0; io_sel = 3'd0;
    for (int i = 0; i < 3; i++) step();
    chk("t5_dout_held", io_dout, 8'h00);
    io_wr = 1; io_sel = 3'd4;
    step();
    io_en = 0;
    bus_rd(3'd1);
    chk("t5_rx_kept", io_dout, 8'h02);
    bus_rd(3'd0);
    chk("t5_rx_byte", io_dout, 8'h33);

`ifdef MMIO_CYCLE_CNT_EN
    do_reset();
    for (int i = 0; i < 99; i++) idle_step();
    bus_rd(3'd4);
    chk("t6_cnt_b0", io_dout, 8'd99);
    bus_rd(3'd5);
    chk("t6_cnt_b1", io_dout, 8'd0);
`endif

    // Randomized traffic in phases with different UART pacing.
    for (int ph = 0; ph < 6; ph++) begin
      for (int i = 0; i < 500; i++) begin
        int unsigned r;
        rdy      = ($urandom_range(0, 7) != 0);
        io_en    = ($urandom_range(0, 2) != 0);
        io_wr    = $urandom_range(0, 1) != 0;
        r        = $urandom_range(0, 9);
        io_sel   = (r < 4) ? 3'd0 : (r < 6) ? 3'd1 : (r == 6) ? 3'd4 : 3'($urandom);
        io_din   = 8'($urandom);
        tx_ready = ($urandom_range(0, 5) < ph);
        rx_valid = ($urandom_range(0, 5) >= ph);
        rx_data  = 8'($urandom);
        step();
      end
    end

    // Asynchronous reset in the middle of a cycle with both FIFOs busy.
    tx_ready = 0; rx_valid = 1; rx_data = 8'h5C;
    for (int i = 0; i < 16; i++) bus_wr(3'd0, 8'(i));
    rx_valid = 0;
    bus_rd(3'd0);
    #2;
    rst_n = 0;
    #1;
    chk("arst_io_dout", io_dout, 8'h00);
    chk("arst_io_full", io_full, 1'b0);
    chk("arst_finish", program_finish, 1'b0);
    chk("arst_tx_valid", tx_valid, 1'b0);
    chk("arst_rx_ready", rx_ready, 1'b1);
    do_reset();
    for (int i = 0; i < 4; i++) idle_step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
